// File: rtl/cache_pkg.sv
// Shared parameters, FSM state encoding and address layout for the 4-way
// set-associative data cache controller.
package cache_pkg;

    localparam int SET_BITS = 4;
    localparam int SETS     = 16;
    localparam int WAYS     = 4;
    localparam int WORDS    = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = ADDR_W - 8;
    localparam int PLRU_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_REFILL_REQ  = 3'd2,
        ST_REFILL_WAIT = 3'd3,
        ST_WRITE_REQ   = 3'd4,
        ST_RESP        = 3'd5
    } cache_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [SET_BITS-1:0] set;
        logic [1:0]          word;
        logic [1:0]          byte_idx;
    } cache_addr_t;

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one 4-way set: picks the refill victim and computes the
// tree bits after an access. Purely combinational; state lives in the caller.
module cache_plru
    import cache_pkg::*;
(
    input  logic [PLRU_W-1:0] bits,
    input  logic [1:0]        access_way,
    input  logic [WAYS-1:0]   valid,
    output logic [1:0]        victim,
    output logic [PLRU_W-1:0] bits_next
);

    // Victim choice: free ways are preferred over evicting live lines.
    always_comb begin
        victim = 2'd0;
        if (!valid[0]) begin
            victim = 2'd0;
        end else if (!valid[1]) begin
            victim = 2'd1;
        end else if (!valid[2]) begin
            victim = 2'd2;
        end else if (!valid[3]) begin
            victim = 2'd3;
        end else if (!bits[0]) begin
            victim = {1'b0, bits[1]};
        end else begin
            victim = {1'b1, bits[2]};
        end
    end

    // Point the tree away from the way just touched.
    always_comb begin
        bits_next    = bits;
        bits_next[0] = ~access_way[1];
        if (!access_way[1]) begin
            bits_next[1] = ~access_way[0];
        end else begin
            bits_next[2] = ~access_way[0];
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for the 4-way set-associative write-through data
// cache: one CPU request at a time, word-by-word refill on read miss.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ready_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    cache_state_e      state_r, state_n;
    cache_addr_t       addr_r, addr_n;
    logic              we_r, we_n;
    logic [DATA_W-1:0] wdata_r, wdata_n;
    logic [DATA_W-1:0] rdata_r, rdata_n;
    logic [1:0]        cnt_r, cnt_n;
    logic [1:0]        way_r, way_n;

    logic [WAYS-1:0]   valid_r    [SETS];
    logic [PLRU_W-1:0] plru_r     [SETS];
    logic [TAG_W-1:0]  tag_mem_r  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem_r [SETS][WAYS][WORDS];

    logic [WAYS-1:0]   set_valid_s;
    logic [WAYS-1:0]   hit_vec_s;
    logic              hit_any_s;
    logic [1:0]        hit_way_s;
    logic [1:0]        victim_s;
    logic [1:0]        plru_way_s;
    logic [PLRU_W-1:0] plru_next_s;
    logic              flush_s;
    logic              accept_s;
    logic              plru_we_s;
    logic              valid_set_s;
    logic              tag_we_s;
    logic              data_we_s;
    logic [1:0]        data_way_s;
    logic [1:0]        data_word_s;
    logic [DATA_W-1:0] data_wdata_s;

    assign set_valid_s = valid_r[addr_r.set];
    assign flush_s     = (state_r == ST_IDLE) && flush_i;
    assign accept_s    = (state_r == ST_IDLE) && cpu_req_i && !flush_i;
    assign cpu_ready_o = (state_r == ST_IDLE) && !flush_i;
    assign hit_any_s   = |hit_vec_s;
    // Lookup updates the tree for the hit way; refill completion uses the victim.
    assign plru_way_s  = (state_r == ST_LOOKUP) ? hit_way_s : way_r;

    // Tag compare across the four ways of the latched set.
    always_comb begin
        hit_vec_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = set_valid_s[w] && (tag_mem_r[addr_r.set][w] == addr_r.tag);
        end
    end

    // Encode the hit vector; at most one way can match.
    always_comb begin
        hit_way_s = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec_s[w]) begin
                hit_way_s = w[1:0];
            end else begin
                hit_way_s = hit_way_s;
            end
        end
    end

    cache_plru u_plru (
        .bits       (plru_r[addr_r.set]),
        .access_way (plru_way_s),
        .valid      (set_valid_s),
        .victim     (victim_s),
        .bits_next  (plru_next_s)
    );

    // Next-state logic and array write strobes.
    always_comb begin
        state_n      = state_r;
        addr_n       = addr_r;
        we_n         = we_r;
        wdata_n      = wdata_r;
        rdata_n      = rdata_r;
        cnt_n        = cnt_r;
        way_n        = way_r;
        plru_we_s    = 1'b0;
        valid_set_s  = 1'b0;
        tag_we_s     = 1'b0;
        data_we_s    = 1'b0;
        data_way_s   = way_r;
        data_word_s  = cnt_r;
        data_wdata_s = mem_rdata_i;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_n          = cpu_addr_i;
                    addr_n.byte_idx = 2'b00;
                    we_n            = cpu_we_i;
                    wdata_n         = cpu_wdata_i;
                    state_n         = ST_LOOKUP;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_any_s) begin
                    plru_we_s = 1'b1;
                    way_n     = hit_way_s;
                    if (we_r) begin
                        data_we_s    = 1'b1;
                        data_way_s   = hit_way_s;
                        data_word_s  = addr_r.word;
                        data_wdata_s = wdata_r;
                        state_n      = ST_WRITE_REQ;
                    end else begin
                        rdata_n = data_mem_r[addr_r.set][hit_way_s][addr_r.word];
                        state_n = ST_RESP;
                    end
                end else if (we_r) begin
                    state_n = ST_WRITE_REQ;
                end else begin
                    way_n   = victim_s;
                    cnt_n   = 2'd0;
                    state_n = ST_REFILL_REQ;
                end
            end
            ST_REFILL_REQ: begin
                if (mem_gnt_i) begin
                    state_n = ST_REFILL_WAIT;
                end else begin
                    state_n = ST_REFILL_REQ;
                end
            end
            ST_REFILL_WAIT: begin
                if (mem_rvalid_i) begin
                    data_we_s = 1'b1;
                    if (cnt_r == addr_r.word) begin
                        rdata_n = mem_rdata_i;
                    end else begin
                        rdata_n = rdata_r;
                    end
                    if (cnt_r == 2'd3) begin
                        tag_we_s    = 1'b1;
                        valid_set_s = 1'b1;
                        plru_we_s   = 1'b1;
                        state_n     = ST_RESP;
                    end else begin
                        cnt_n   = cnt_r + 2'd1;
                        state_n = ST_REFILL_REQ;
                    end
                end else begin
                    state_n = ST_REFILL_WAIT;
                end
            end
            ST_WRITE_REQ: begin
                if (mem_gnt_i) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_WRITE_REQ;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state and latched request fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
            rdata_r <= '0;
            cnt_r   <= 2'd0;
            way_r   <= 2'd0;
        end else begin
            state_r <= state_n;
            addr_r  <= addr_n;
            we_r    <= we_n;
            wdata_r <= wdata_n;
            rdata_r <= rdata_n;
            cnt_r   <= cnt_n;
            way_r   <= way_n;
        end
    end

    // Valid and PLRU bits: cleared by reset and by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SETS; i++) begin
                valid_r[i] <= '0;
                plru_r[i]  <= '0;
            end
        end else if (flush_s) begin
            for (int i = 0; i < SETS; i++) begin
                valid_r[i] <= '0;
                plru_r[i]  <= '0;
            end
        end else begin
            if (plru_we_s) begin
                plru_r[addr_r.set] <= plru_next_s;
            end
            if (valid_set_s) begin
                valid_r[addr_r.set][way_r] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are qualified by valid so need no reset.
    always_ff @(posedge clk_i) begin
        if (data_we_s) begin
            data_mem_r[addr_r.set][data_way_s][data_word_s] <= data_wdata_s;
        end
        if (tag_we_s) begin
            tag_mem_r[addr_r.set][way_r] <= addr_r.tag;
        end
    end

    // Bus and response outputs decoded from state and latched fields only.
    always_comb begin
        cpu_rvalid_o = 1'b0;
        cpu_rdata_o  = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (state_r)
            ST_REFILL_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_r.tag, addr_r.set, cnt_r, 2'b00};
            end
            ST_WRITE_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_r;
                mem_wdata_o = wdata_r;
            end
            ST_RESP: begin
                cpu_rvalid_o = 1'b1;
                if (!we_r) begin
                    cpu_rdata_o = rdata_r;
                end else begin
                    cpu_rdata_o = '0;
                end
            end
            default: begin
                cpu_rvalid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with a simple zero-wait memory
// model whose grant and read-data timing can be stalled or forced.
module tb_cache_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic        cpu_ready_o;
    logic        cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic        gnt_en;
    logic        rv_force;
    logic [31:0] force_data;
    logic        rv_r = 1'b0;
    logic [31:0] rd_r = 32'd0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;
    logic [31:0] rd_addr_log [0:255];
    bit          wr_v [4096];
    logic [31:0] wr_d [4096];

    int n_cmp = 0;
    int n_err = 0;

    cache_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_ready_o  (cpu_ready_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    assign mem_gnt_i    = mem_req_o & gnt_en;
    assign mem_rvalid_i = rv_r | rv_force;
    assign mem_rdata_i  = rv_force ? force_data : rd_r;

    // Memory contents: written words, else 0xA0..0xA3 for line 0x100, else addr^0x5A5A0000.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (wr_v[a[13:2]]) begin
            return wr_d[a[13:2]];
        end else if (a[31:4] == 28'h0000010) begin
            return 32'h0000_00A0 + {30'd0, a[3:2]};
        end else begin
            return a ^ 32'h5A5A_0000;
        end
    endfunction

    // Memory responder: read data one cycle after the granted request.
    always @(posedge clk_i) begin
        rv_r <= 1'b0;
        if (mem_req_o && mem_gnt_i) begin
            if (mem_we_o) begin
                wr_v[mem_addr_o[13:2]] <= 1'b1;
                wr_d[mem_addr_o[13:2]] <= mem_wdata_o;
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= mem_addr_o;
                last_wr_data <= mem_wdata_o;
            end else begin
                rv_r <= 1'b1;
                rd_r <= mem_read(mem_addr_o);
                rd_addr_log[rd_cnt[7:0]] <= mem_addr_o;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input int exp_lat, input int exp_reads, input string tag);
        int k;
        int rd0;
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = a;
        #1;
        check({tag, " ready"}, {31'd0, cpu_ready_o}, 32'd1);
        rd0 = rd_cnt;
        @(posedge clk_i);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        k = 1;
        while (!cpu_rvalid_o && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        check({tag, " latency"}, k, exp_lat);
        check({tag, " rdata"}, cpu_rdata_o, exp_d);
        check({tag, " memreads"}, rd_cnt - rd0, exp_reads);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        int k;
        int wr0;
        @(negedge clk_i);
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b1;
        cpu_addr_i  = a;
        cpu_wdata_i = d;
        #1;
        check({tag, " ready"}, {31'd0, cpu_ready_o}, 32'd1);
        wr0 = wr_cnt;
        @(posedge clk_i);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        k = 1;
        while (!cpu_rvalid_o && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        check({tag, " latency"}, k, 32'd3);
        check({tag, " rdata"}, cpu_rdata_o, 32'd0);
        check({tag, " memwrites"}, wr_cnt - wr0, 32'd1);
        check({tag, " wr_addr"}, last_wr_addr, {a[31:2], 2'b00});
        check({tag, " wr_data"}, last_wr_data, d);
    endtask

    initial begin
        int k;
        int rd0;
        rst_ni      = 1'b1;
        flush_i     = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'd0;
        cpu_wdata_i = 32'd0;
        gnt_en      = 1'b1;
        rv_force    = 1'b0;
        force_data  = 32'd0;
        #3 rst_ni = 1'b0;

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst ready", {31'd0, cpu_ready_o}, 32'd1);
        check("rst rvalid", {31'd0, cpu_rvalid_o}, 32'd0);
        check("rst rdata", cpu_rdata_o, 32'd0);
        check("rst mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst mem_we", {31'd0, mem_we_o}, 32'd0);
        check("rst mem_addr", mem_addr_o, 32'd0);
        check("rst mem_wdata", mem_wdata_o, 32'd0);
        flush_i = 1'b1;
        #1;
        check("rst ready_flush", {31'd0, cpu_ready_o}, 32'd0);
        flush_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Cold read miss, then hit
        do_read(32'h0000_0104, 32'h0000_00A1, 10, 4, "cold_rd");
        check("cold_rd addr0", rd_addr_log[0], 32'h0000_0100);
        check("cold_rd addr1", rd_addr_log[1], 32'h0000_0104);
        check("cold_rd addr2", rd_addr_log[2], 32'h0000_0108);
        check("cold_rd addr3", rd_addr_log[3], 32'h0000_010C);
        do_read(32'h0000_0104, 32'h0000_00A1, 2, 0, "hit_rd");

        // Write hit and write miss (no allocate)
        do_write(32'h0000_0104, 32'hDEAD_BEEF, "wr_hit");
        do_read(32'h0000_0104, 32'hDEAD_BEEF, 2, 0, "rd_after_wr");
        do_write(32'h0000_2000, 32'h1234_5678, "wr_miss");
        do_read(32'h0000_2000, 32'h1234_5678, 10, 4, "rd_no_alloc");

        // Flush beats a same-cycle request
        @(negedge clk_i);
        flush_i    = 1'b1;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0104;
        #1;
        check("flush ready", {31'd0, cpu_ready_o}, 32'd0);
        @(negedge clk_i);
        flush_i   = 1'b0;
        cpu_req_i = 1'b0;
        #1;
        check("flush not_accepted", {31'd0, cpu_ready_o}, 32'd1);
        @(negedge clk_i);
        check("flush no_rvalid", {31'd0, cpu_rvalid_o}, 32'd0);
        check("flush no_mem_req", {31'd0, mem_req_o}, 32'd0);
        do_read(32'h0000_0104, 32'hDEAD_BEEF, 10, 4, "rd_after_flush");

        // Replacement in set 0
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        do_read(32'h0000_0000, 32'h5A5A_0000, 10, 4, "fill0");
        do_read(32'h0000_0100, 32'h0000_00A0, 10, 4, "fill1");
        do_read(32'h0000_0200, 32'h5A5A_0200, 10, 4, "fill2");
        do_read(32'h0000_0300, 32'h5A5A_0300, 10, 4, "fill3");
        do_read(32'h0000_0000, 32'h5A5A_0000, 2, 0, "rehit0");
        do_read(32'h0000_0400, 32'h5A5A_0400, 10, 4, "repl_400");
        do_read(32'h0000_0200, 32'h5A5A_0200, 10, 4, "evicted_200");
        do_read(32'h0000_0000, 32'h5A5A_0000, 2, 0, "kept_000");
        do_read(32'h0000_0100, 32'h0000_00A0, 10, 4, "evicted_100");
        do_read(32'h0000_0400, 32'h5A5A_0400, 2, 0, "kept_400");
        do_read(32'h0000_0300, 32'h5A5A_0300, 10, 4, "evicted_300");

        // Grant stall: request held stable for 5 cycles
        gnt_en = 1'b0;
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0504;
        @(posedge clk_i);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        k = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            k++;
            check("stall mem_req", {31'd0, mem_req_o}, 32'd1);
            check("stall mem_we", {31'd0, mem_we_o}, 32'd0);
            check("stall mem_addr", mem_addr_o, 32'h0000_0500);
        end
        gnt_en = 1'b1;
        while (!cpu_rvalid_o && k < 60) begin
            @(negedge clk_i);
            k++;
        end
        check("stall latency", k, 32'd14);
        check("stall rdata", cpu_rdata_o, 32'h5A5A_0504);

        // Reset in the middle of a refill
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_3000;
        rd0 = rd_cnt;
        @(posedge clk_i);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        k = 1;
        while (!((rd_cnt - rd0 == 2) && mem_req_o) && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        check("midrst reached_word2", mem_addr_o, 32'h0000_3008);
        rst_ni = 1'b0;
        #1;
        check("midrst mem_req", {31'd0, mem_req_o}, 32'd0);
        check("midrst mem_addr", mem_addr_o, 32'd0);
        check("midrst ready", {31'd0, cpu_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_ni     = 1'b1;
        rv_force   = 1'b1;
        force_data = 32'hBAD0_BAD0;
        @(negedge clk_i);
        rv_force = 1'b0;
        check("late_rv no_rvalid", {31'd0, cpu_rvalid_o}, 32'd0);
        check("late_rv ready", {31'd0, cpu_ready_o}, 32'd1);
        do_read(32'h0000_3000, 32'h5A5A_3000, 10, 4, "rd_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
